// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SPI_MAX_WIDTH_LOG_DEF = 4;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Transmit/receive handshake bundle between a host and spi_master_ctrl.
interface spi_master_ctrl_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 2**SPI_MAX_WIDTH_LOG_DEF
);

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: down-counter that pulses tick on every CLK_DIV-th enabled cycle.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one frame of 1..2^SPI_MAX_WIDTH_LOG bits per accepted tx handshake, modes 0-3.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input (sample mosi instead of miso).
//
// state    | meaning
// ST_IDLE  | cs_n high, tx_ready high, sclk tracks live cpol
// ST_SETUP | cs_n low, first half-period before the first sclk edge
// ST_SHIFT | sclk toggling every CLK_DIV cycles, 2N edges total
// ST_HOLD  | last half-period after the final edge, then cs_n rises
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEF,
  parameter int CLK_DIV           = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width,
  spi_master_ctrl_if.slave             bus,
  output logic                         busy,
  output logic                         sclk,
  output logic                         cs_n,
  output logic                         mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                         loopback,
`endif
  input  logic                         miso
);

  localparam int DW = 2**SPI_MAX_WIDTH_LOG;
  localparam int EW = SPI_MAX_WIDTH_LOG + 2;

  spi_state_t    state, state_nxt;
  logic          tick, tick_en;
  logic          accept, toggle_en, frame_done;
  logic          leading, sample_bit;
  logic          cpha_q;
  logic [EW-1:0] edges_left;
  logic [DW-1:0] tx_aligned, tx_sr, rx_sr, rx_data_q;
  logic          rx_valid_q;

  assign tick_en = (state != ST_IDLE);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (~tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    toggle_en  = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          toggle_en = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          toggle_en = 1'b1;
          if (edges_left == EW'(1)) state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Left-justify so the frame MSB always leaves from tx_sr[DW-1]; DW-1-spi_width == ~spi_width.
  assign tx_aligned = bus.tx_data << (~spi_width);
  // edges_left starts even, so an even count marks the leading edge of each bit.
  assign leading    = ~edges_left[0];

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cpha_q     <= 1'b0;
      edges_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state == ST_IDLE) sclk <= cpol;
      if (accept) begin
        cs_n       <= 1'b0;
        cpha_q     <= cpha;
        edges_left <= {1'b0, spi_width, 1'b0} + EW'(2);
        rx_sr      <= '0;
        if (cpha) begin
          tx_sr <= tx_aligned;
        end else begin
          mosi  <= tx_aligned[DW-1];
          tx_sr <= tx_aligned << 1;
        end
      end
      if (toggle_en) begin
        sclk       <= ~sclk;
        edges_left <= edges_left - EW'(1);
        if (leading ^ cpha_q) begin
          rx_sr <= {rx_sr[DW-2:0], sample_bit};
        end else if (edges_left != EW'(1)) begin
          // the final trailing edge in CPHA=0 has no bit left; mosi keeps the last one
          mosi  <= tx_sr[DW-1];
          tx_sr <= tx_sr << 1;
        end
      end
      if (frame_done) begin
        cs_n       <= 1'b1;
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sr;
      end
    end
  end

  assign busy         = (state != ST_IDLE);
  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl (CLK_DIV=4, 16-bit max frame).
`timescale 1ns/1ps
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [3:0]  spi_width = 4'd0;
  logic        lb_sel = 1'b1;
  logic        slave_miso = 1'b0;
  logic        miso;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;

  int checks = 0;
  int errors = 0;
  int tog_cnt = 0, low_cyc = 0, rxv_cnt = 0, hi_run = 0, last_gap = 0, bad_mosi = 0;
  logic sclk_prev = 1'b0, mosi_prev = 1'b0, cs_prev = 1'b1;
  logic [15:0] slave_sr = 16'h0, slave_cap = 16'h0;

  spi_master_ctrl_if #(.DATA_W(16)) bus();

  assign miso = lb_sel ? mosi : slave_miso;

  spi_master_ctrl #(.SPI_MAX_WIDTH_LOG(4), .CLK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpol      (cpol),
    .cpha      (cpha),
    .spi_width (spi_width),
    .bus       (bus),
    .busy      (busy),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback  (lb_sel),
`endif
    .miso      (miso)
  );

  always #5 clk = ~clk;

  // Bus monitor, sampled on the falling clk edge away from DUT updates.
  always @(negedge clk) begin
    if (!cs_n) begin
      low_cyc++;
      if (sclk !== sclk_prev) tog_cnt++;
      if (!cs_prev && (mosi !== mosi_prev) && !(sclk_prev === 1'b1 && sclk === 1'b0)) bad_mosi++;
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (bus.rx_valid) rxv_cnt++;
    sclk_prev = sclk;
    mosi_prev = mosi;
    cs_prev   = cs_n;
  end

  // Mode-3 slave: drives on falling sclk, captures mosi on rising sclk.
  always @(negedge sclk) if (!cs_n) begin
    slave_miso = slave_sr[15];
    slave_sr   = slave_sr << 1;
  end
  always @(posedge sclk) if (!cs_n) slave_cap = {slave_cap[14:0], mosi};

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    tog_cnt = 0; low_cyc = 0; rxv_cnt = 0; bad_mosi = 0;
  endtask

  task automatic start_frame(input logic pol, input logic pha, input logic [3:0] w, input logic [15:0] d);
    cpol = pol; cpha = pha; spi_width = w; bus.tx_data = d;
    idle_cycles(2);
    clear_mon();
    bus.tx_valid = 1'b1;
    idle_cycles(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output logic [15:0] rx, output logic cs_at);
    rx = 16'h0; cs_at = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (bus.rx_valid) begin
        rx = bus.rx_data; cs_at = cs_n;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL rx_timeout: no rx_valid within 1000 cycles");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cycles(3);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0000", bus.rx_data); end
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_mode0();
    logic [15:0] rx;
    logic cs_at;
    lb_sel = 1'b1;
    start_frame(1'b0, 1'b0, 4'd7, 16'h00A5);
    wait_rx(rx, cs_at);
    checks++; if (rx !== 16'h00A5) begin errors++; $display("FAIL mode0_rx: got %h expected 00a5", rx); end
    checks++; if (cs_at !== 1'b1) begin errors++; $display("FAIL mode0_cs_at_valid: got %b expected 1", cs_at); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL mode0_ready_at_valid: got %b expected 1", bus.tx_ready); end
    idle_cycles(5);
    checks++; if (tog_cnt != 16) begin errors++; $display("FAIL mode0_toggles: got %0d expected 16", tog_cnt); end
    checks++; if (low_cyc != 68) begin errors++; $display("FAIL mode0_cs_low: got %0d expected 68", low_cyc); end
    checks++; if (rxv_cnt != 1) begin errors++; $display("FAIL mode0_rx_valid_count: got %0d expected 1", rxv_cnt); end
    checks++; if (bad_mosi != 0) begin errors++; $display("FAIL mode0_mosi_edge: got %0d off-edge changes expected 0", bad_mosi); end
    checks++; if (bus.rx_data !== 16'h00A5) begin errors++; $display("FAIL mode0_rx_hold: got %h expected 00a5", bus.rx_data); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL mode0_mosi_hold: got %b expected 1", mosi); end
  endtask

  task automatic test_mode3();
    logic [15:0] rx;
    logic cs_at;
    lb_sel = 1'b0;
    slave_sr = 16'h6000; slave_cap = 16'h0;
    cpol = 1'b1;
    idle_cycles(2);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL mode3_idle_sclk: got %b expected 1", sclk); end
    start_frame(1'b1, 1'b1, 4'd3, 16'h0009);
    wait_rx(rx, cs_at);
    checks++; if (rx !== 16'h0006) begin errors++; $display("FAIL mode3_rx: got %h expected 0006", rx); end
    idle_cycles(5);
    checks++; if (tog_cnt != 8) begin errors++; $display("FAIL mode3_toggles: got %0d expected 8", tog_cnt); end
    checks++; if (low_cyc != 36) begin errors++; $display("FAIL mode3_cs_low: got %0d expected 36", low_cyc); end
    checks++; if (slave_cap !== 16'h0009) begin errors++; $display("FAIL mode3_slave_cap: got %h expected 0009", slave_cap); end
    checks++; if (bad_mosi != 0) begin errors++; $display("FAIL mode3_mosi_edge: got %0d off-edge changes expected 0", bad_mosi); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL mode3_end_sclk: got %b expected 1", sclk); end
    lb_sel = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx1, rx2;
    logic cs1, cs2;
    cpol = 1'b0; cpha = 1'b0; spi_width = 4'd7; bus.tx_data = 16'h0012;
    idle_cycles(2);
    clear_mon();
    last_gap = 0;
    bus.tx_valid = 1'b1;
    idle_cycles(1);
    bus.tx_data = 16'h0034;
    wait_rx(rx1, cs1);
    idle_cycles(1);
    bus.tx_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got busy %b expected 1", busy); end
    wait_rx(rx2, cs2);
    idle_cycles(3);
    checks++; if (rx1 !== 16'h0012) begin errors++; $display("FAIL b2b_rx1: got %h expected 0012", rx1); end
    checks++; if (rx2 !== 16'h0034) begin errors++; $display("FAIL b2b_rx2: got %h expected 0034", rx2); end
    checks++; if (last_gap != 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected 1", last_gap); end
    checks++; if (rxv_cnt != 2) begin errors++; $display("FAIL b2b_rx_valid_count: got %0d expected 2", rxv_cnt); end
    checks++; if (tog_cnt != 32) begin errors++; $display("FAIL b2b_toggles: got %0d expected 32", tog_cnt); end
  endtask

  task automatic test_cfg_change();
    logic [15:0] rx;
    logic cs_at;
    start_frame(1'b0, 1'b0, 4'd7, 16'h00C3);
    idle_cycles(20);
    cpha = 1'b1; spi_width = 4'd3; bus.tx_data = 16'h000A;
    wait_rx(rx, cs_at);
    idle_cycles(3);
    checks++; if (rx !== 16'h00C3) begin errors++; $display("FAIL cfg_cur_rx: got %h expected 00c3", rx); end
    checks++; if (tog_cnt != 16) begin errors++; $display("FAIL cfg_cur_toggles: got %0d expected 16", tog_cnt); end
    checks++; if (low_cyc != 68) begin errors++; $display("FAIL cfg_cur_cs_low: got %0d expected 68", low_cyc); end
    start_frame(1'b0, 1'b1, 4'd3, 16'h000A);
    wait_rx(rx, cs_at);
    idle_cycles(3);
    checks++; if (rx !== 16'h000A) begin errors++; $display("FAIL cfg_next_rx: got %h expected 000a", rx); end
    checks++; if (tog_cnt != 8) begin errors++; $display("FAIL cfg_next_toggles: got %0d expected 8", tog_cnt); end
    checks++; if (low_cyc != 36) begin errors++; $display("FAIL cfg_next_cs_low: got %0d expected 36", low_cyc); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rx;
    logic cs_at;
    bit hit;
    hit = 1'b0;
    start_frame(1'b0, 1'b0, 4'd7, 16'h00A5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tog_cnt >= 5) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach: got %0d toggles expected 5", tog_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rstmid_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (bus.rx_data !== 16'h0) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 0000", bus.rx_data); end
    idle_cycles(2);
    rst_n = 1'b1;
    clear_mon();
    idle_cycles(100);
    checks++; if (rxv_cnt != 0) begin errors++; $display("FAIL rstmid_no_rx_valid: got %0d expected 0", rxv_cnt); end
    start_frame(1'b0, 1'b0, 4'd7, 16'h005A);
    wait_rx(rx, cs_at);
    idle_cycles(3);
    checks++; if (rx !== 16'h005A) begin errors++; $display("FAIL rstmid_next_rx: got %h expected 005a", rx); end
    checks++; if (tog_cnt != 16) begin errors++; $display("FAIL rstmid_next_toggles: got %0d expected 16", tog_cnt); end
  endtask

  task automatic test_width_bounds();
    logic [15:0] rx;
    logic cs_at;
    start_frame(1'b0, 1'b0, 4'd0, 16'h0001);
    wait_rx(rx, cs_at);
    idle_cycles(3);
    checks++; if (rx !== 16'h0001) begin errors++; $display("FAIL w0_rx: got %h expected 0001", rx); end
    checks++; if (tog_cnt != 2) begin errors++; $display("FAIL w0_toggles: got %0d expected 2", tog_cnt); end
    checks++; if (low_cyc != 12) begin errors++; $display("FAIL w0_cs_low: got %0d expected 12", low_cyc); end
    start_frame(1'b0, 1'b0, 4'd15, 16'hFFFF);
    wait_rx(rx, cs_at);
    idle_cycles(3);
    checks++; if (rx !== 16'hFFFF) begin errors++; $display("FAIL w15_rx: got %h expected ffff", rx); end
    checks++; if (tog_cnt != 32) begin errors++; $display("FAIL w15_toggles: got %0d expected 32", tog_cnt); end
    checks++; if (low_cyc != 132) begin errors++; $display("FAIL w15_cs_low: got %0d expected 132", low_cyc); end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 16'h0;
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    test_width_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter SPI_MAX_WIDTH_LOG, default 4: log2 of the maximum frame length; maximum frame is 2^SPI_MAX_WIDTH_LOG bits.
REQ-002 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal values are CLK_DIV >= 2.
REQ-003 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpol, cpha  input  1 each  SPI mode from the config register.
REQ-005 spi_width  input  SPI_MAX_WIDTH_LOG  frame length minus one, so N = spi_width+1 bits.
REQ-006 tx_valid  input  1 / tx_ready  output  1 / tx_data  input  2^SPI_MAX_WIDTH_LOG  transmit handshake; tx_data is right-aligned.
REQ-007 rx_valid  output  1 / rx_data  output  2^SPI_MAX_WIDTH_LOG  received frame, right-aligned.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 sclk, cs_n, mosi  output  1 each; miso  input  1.

Function
REQ-010 FSM states are IDLE, SETUP, SHIFT and HOLD; tx_ready is high only in IDLE.
REQ-011 Transfer acceptance and configuration capture:
- A transfer is accepted when tx_valid && tx_ready.
- cpol, cpha, spi_width and tx_data are latched at acceptance.
- Input changes during a transfer are ignored.
REQ-012 On the cycle after acceptance, cs_n goes low and the FSM enters SETUP.
REQ-013 Edge timing:
- SETUP lasts CLK_DIV cycles.
- SHIFT produces 2N sclk toggles, spaced CLK_DIV cycles apart, the first at the end of SETUP.
- HOLD lasts CLK_DIV cycles after the last toggle.
- cs_n then rises and the FSM returns to IDLE.
REQ-014 Total cs_n-low time is CLK_DIV*(2N+1) cycles.
REQ-015 Bit order is MSB-first, starting at bit spi_width of tx_data.
REQ-016 CPHA=0: bit spi_width is on mosi when cs_n falls; the leading edge samples miso; the trailing edge shifts out the next bit.
REQ-017 CPHA=1: the leading edge shifts out the next bit; the trailing edge samples miso.
REQ-018 sclk idle level:
- In IDLE, sclk follows live cpol, registered one cycle.
- During a transfer, sclk idles at the latched cpol.
REQ-019 rx_valid pulses high for exactly one cycle, coincident with the cycle cs_n rises. rx_data holds the N sampled bits with the last-sampled bit at bit 0 and upper bits zero.
REQ-020 rx_data holds its value until the next rx_valid.
REQ-021 Back-to-back transfers:
- tx_ready is high from the cycle cs_n rises.
- A new acceptance in that cycle starts the next frame with cs_n high for exactly one cycle.
REQ-022 spi_width=0 (N=1) and spi_width=all-ones (full width) SHALL both operate without special-case timing.
REQ-023 mosi holds its last driven bit during HOLD and IDLE.

Reset
REQ-024 rst_n low forces, at any time including mid-transfer:
- state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1.
- Clear the shift and divider counters.
REQ-025 After reset release, no rx_valid is generated for an aborted frame.

Configuration
REQ-026 Macro SPI_MASTER_LOOPBACK_EN behaviour:
- Defined: adds input loopback (1 bit). When loopback=1, sampling uses internal mosi instead of miso.
- Undefined: the port is absent and miso is always sampled.

Structure
REQ-027 Package spi_pkg holds the FSM state enum, the SPI mode constants (MODE0..MODE3 as {cpol,cpha}) and the default SPI_MAX_WIDTH_LOG.
REQ-028 Sub-module spi_clk_tick generates the CLK_DIV half-period tick, with enable and synchronous clear.

Verification
REQ-029 Mode 0 frame:
- Stimulus: CLK_DIV=4, spi_width=7, tx_data=0xA5, miso looped to mosi (or loopback=1).
- Response: 16 sclk toggles, cs_n low 68 cycles, rx_data=0x00A5, one rx_valid.
REQ-030 Mode 3 frame:
- Stimulus: spi_width=3, tx_data=0x9, slave model returning 0x6.
- Response: sclk idles 1, data changes on falling edges, rx_data=0x0006.
REQ-031 Back-to-back frames:
- Stimulus: tx_valid held high for two frames, 0x12 then 0x34.
- Response: cs_n high exactly 1 cycle between frames, two rx_valid pulses.
REQ-032 Mid-transfer config change:
- Stimulus: change cpha and spi_width mid-frame.
- Response: the current frame completes with the latched settings; the next frame uses the new settings.
REQ-033 Reset mid-transfer:
- Stimulus: assert rst_n low at the 5th sclk toggle.
- Response: cs_n=1 and sclk=0 immediately, no rx_valid, and the next frame is correct.
REQ-034 Width boundaries:
- Stimulus: spi_width=0 with tx_data=1, then spi_width=15 with tx_data=0xFFFF.
- Response: 2 and 32 toggles respectively; rx_data=0x0001 and 0xFFFF in loopback.
